// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline sequencing controller.
package pipe_ctrl_pkg;

   localparam int DEF_REG_W          = 5;
   localparam int DEF_MEM_TIMEOUT    = 255;
   localparam int DEF_LOAD_STALL_CYC = 1;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Encoding 3 is unused; the controller folds it onto ST_RUN.
   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_e;

   // One cycle's worth of pipeline-buffer control.
   // buf_en[0] is IF/ID, buf_en[3] is MEM/WB.
   typedef struct packed {
      logic       pc_en;
      logic [3:0] buf_en;
      logic       buf1_flush;
      logic       buf2_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, buf_en: 4'b0000, buf1_flush: 1'b1, buf2_flush: 1'b1};
   localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, buf_en: 4'b0000, buf1_flush: 1'b0, buf2_flush: 1'b0};
   localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, buf_en: 4'b1111, buf1_flush: 1'b0, buf2_flush: 1'b0};
   localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, buf_en: 4'b1111, buf1_flush: 1'b1, buf2_flush: 1'b1};
   // Hold PC and IF/ID, push a NOP into ID/EX, let the back end drain.
   localparam ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, buf_en: 4'b1110, buf1_flush: 1'b0, buf2_flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
// Kept standalone so a forwarding unit can share it.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = DEF_REG_W
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_memread,
   output logic             load_use
);

   // $zero is never a real dependency
   assign load_use = ex_memread & (ex_rt != REG_W'(REG_ZERO)) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for PC and the IF/ID, ID/EX, EX/MEM, MEM/WB buffers:
// load-use bubbles, taken-branch flush, data-memory freeze with timeout.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise the counter ports read as zero.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_STALL_CYC = DEF_LOAD_STALL_CYC,
   parameter int MEM_TIMEOUT    = DEF_MEM_TIMEOUT,
   parameter int REG_W          = DEF_REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             buf1_en,
   output logic             buf2_en,
   output logic             buf3_en,
   output logic             buf4_en,
   output logic             buf1_flush,
   output logic             buf2_flush,
   output logic             mem_err,
   output logic [1:0]       state_o,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count,
   output logic [31:0]      wait_cycles
);

   localparam logic [2:0] STALL_LAST = 3'(LOAD_STALL_CYC - 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d, st;
   logic [2:0] stall_cnt_q, stall_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;
   logic       load_use, mem_stall, do_run, do_stall;
   ctrl_t      ctrl;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .ex_rt      (ex_rt),
      .ex_memread (ex_memread),
      .load_use   (load_use)
   );

   assign mem_stall = mem_access & ~mem_ready;

   // Decode the state register, folding the unused encoding onto RUN
   always_comb begin
      case (state_q)
         ST_LOAD_STALL, ST_MEM_WAIT: st = state_q;
         default:                    st = ST_RUN;
      endcase
   end

   // Next state, counters and buffer controls; a nonzero stall_cnt in
   // MEM_WAIT marks a load stall that was suspended by the freeze
   always_comb begin
      state_d     = st;
      stall_cnt_d = stall_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      ctrl        = CTRL_FREEZE;
      do_run      = 1'b0;
      do_stall    = 1'b0;

      case (st)
         ST_MEM_WAIT: begin
            if (!mem_ready) begin
               if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_q == WAIT_LIMIT) mem_err_d = 1'b1;
            end else begin
               // EX/ID were held, so the exit cycle re-runs the normal rules
               wait_cnt_d = 8'd0;
               if (stall_cnt_q != 3'd0) do_stall = 1'b1;
               else                     do_run   = 1'b1;
            end
         end
         ST_LOAD_STALL: begin
            if (mem_stall) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               do_stall = 1'b1;
            end
         end
         default: begin
            if (mem_stall) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               do_run = 1'b1;
            end
         end
      endcase

      if (do_stall) begin
         if (ex_branch_taken) begin
            // Wrong-path load/consumer pair: flush and abandon the stall
            ctrl        = CTRL_BRANCH;
            state_d     = ST_RUN;
            stall_cnt_d = 3'd0;
         end else begin
            ctrl = CTRL_BUBBLE;
            if (stall_cnt_q == STALL_LAST) begin
               state_d     = ST_RUN;
               stall_cnt_d = 3'd0;
            end else begin
               state_d     = ST_LOAD_STALL;
               stall_cnt_d = stall_cnt_q + 3'd1;
            end
         end
      end

      if (do_run) begin
         state_d = ST_RUN;
         if (ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
         end else if (load_use) begin
            ctrl = CTRL_BUBBLE;
            if (LOAD_STALL_CYC > 1) begin
               state_d     = ST_LOAD_STALL;
               stall_cnt_d = 3'd1;
            end
         end else begin
            ctrl = CTRL_RUN;
         end
      end

      // Buffers have no reset of their own: flush them while rst is held
      if (rst) ctrl = CTRL_RESET;
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= 3'd0;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign pc_en      = ctrl.pc_en;
   assign buf1_en    = ctrl.buf_en[0];
   assign buf2_en    = ctrl.buf_en[1];
   assign buf3_en    = ctrl.buf_en[2];
   assign buf4_en    = ctrl.buf_en[3];
   assign buf1_flush = ctrl.buf1_flush;
   assign buf2_flush = ctrl.buf2_flush;
   assign mem_err    = mem_err_q & ~rst;
   assign state_o    = state_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q,  flush_count_d;
   logic [31:0] wait_cycles_q,  wait_cycles_d;

   // Saturating event counters derived from the issued controls
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      wait_cycles_d  = wait_cycles_q;
      if (!ctrl.pc_en && (st != ST_MEM_WAIT) && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (ctrl.pc_en && ctrl.buf1_flush && (flush_count_q != '1))
         flush_count_d = flush_count_q + 32'd1;
      if ((st == ST_MEM_WAIT) && (wait_cycles_q != '1))
         wait_cycles_d = wait_cycles_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
         wait_cycles_q  <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
         wait_cycles_q  <= wait_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign wait_cycles  = wait_cycles_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
   assign wait_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Main instance: 2 bubbles per
// load-use, 3-cycle memory timeout. Second instance: default parameters.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       ex_memread, ex_branch_taken, mem_access, mem_ready;

   logic        pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush, mem_err;
   logic [1:0]  state_o;
   logic [31:0] stall_cycles, flush_count, wait_cycles;

   logic        d1_pc_en, d1_buf1_en, d1_buf2_en, d1_buf3_en, d1_buf4_en;
   logic        d1_buf1_flush, d1_buf2_flush, d1_mem_err;
   logic [1:0]  d1_state_o;
   logic [31:0] d1_stall_cycles, d1_flush_count, d1_wait_cycles;

   int total = 0;
   int bad   = 0;

   pipeline_hazard_ctrl #(.LOAD_STALL_CYC(2), .MEM_TIMEOUT(3), .REG_W(5)) u_dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
      .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
      .mem_ready(mem_ready), .pc_en(pc_en), .buf1_en(buf1_en), .buf2_en(buf2_en),
      .buf3_en(buf3_en), .buf4_en(buf4_en), .buf1_flush(buf1_flush),
      .buf2_flush(buf2_flush), .mem_err(mem_err), .state_o(state_o),
      .stall_cycles(stall_cycles), .flush_count(flush_count), .wait_cycles(wait_cycles)
   );

   pipeline_hazard_ctrl u_d1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
      .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
      .mem_ready(mem_ready), .pc_en(d1_pc_en), .buf1_en(d1_buf1_en), .buf2_en(d1_buf2_en),
      .buf3_en(d1_buf3_en), .buf4_en(d1_buf4_en), .buf1_flush(d1_buf1_flush),
      .buf2_flush(d1_buf2_flush), .mem_err(d1_mem_err), .state_o(d1_state_o),
      .stall_cycles(d1_stall_cycles), .flush_count(d1_flush_count), .wait_cycles(d1_wait_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // en5 = {pc_en, buf1_en..buf4_en}, fl2 = {buf1_flush, buf2_flush}
   task automatic chk_out(input string tag, input logic [4:0] en5, input logic [1:0] fl2,
                          input logic err, input logic [1:0] st);
      logic [9:0] obs, exp;
      obs = {pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush, mem_err, state_o};
      exp = {en5, fl2, err, st};
      chk(tag, 32'(obs), 32'(exp));
   endtask

   task automatic chk_d1(input string tag, input logic [4:0] en5, input logic [1:0] st);
      chk(tag, 32'({d1_pc_en, d1_buf1_en, d1_buf2_en, d1_buf3_en, d1_buf4_en, d1_state_o}),
          32'({en5, st}));
   endtask

   task automatic chk_perf(input string tag, input int s, input int f, input int w);
      chk({tag, "_stall"}, stall_cycles, PERF ? 32'(s) : 32'd0);
      chk({tag, "_flush"}, flush_count,  PERF ? 32'(f) : 32'd0);
      chk({tag, "_wait"},  wait_cycles,  PERF ? 32'(w) : 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();

      // Reset: buffers flushed, nothing enabled
      tick(); #1 chk_out("rst0", 5'b00000, 2'b11, 1'b0, 2'd0);
      tick(); #1 chk_out("rst1", 5'b00000, 2'b11, 1'b0, 2'd0);
      chk_perf("perf_rst", 0, 0, 0);
      rst = 1'b0;
      #1 chk_out("run", 5'b11111, 2'b00, 1'b0, 2'd0);
      chk_d1("d1_run", 5'b11111, 2'd0);
      tick();

      // Load-use on rs: exactly two bubble cycles (one for the default instance)
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1 chk_out("lu_c0", 5'b00111, 2'b01, 1'b0, 2'd0);
      chk_d1("d1_lu_c0", 5'b00111, 2'd0);
      tick(); clr_in();
      #1 chk_out("lu_c1", 5'b00111, 2'b01, 1'b0, 2'd1);
      chk_d1("d1_lu_c1", 5'b11111, 2'd0);
      tick();
      #1 chk_out("lu_done", 5'b11111, 2'b00, 1'b0, 2'd0);
      chk_perf("perf_lu", 2, 0, 0);

      // $zero destination, non-load, and rt match
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      #1 chk_out("lu_r0", 5'b11111, 2'b00, 1'b0, 2'd0);
      ex_memread = 1'b0; ex_rt = 5'd9; id_rt = 5'd9;
      #1 chk_out("lu_noload", 5'b11111, 2'b00, 1'b0, 2'd0);
      ex_memread = 1'b1;
      #1 chk_out("lu_rt", 5'b00111, 2'b01, 1'b0, 2'd0);
      tick(); clr_in();
      #1 chk_out("lu_rt1", 5'b00111, 2'b01, 1'b0, 2'd1);
      tick();

      // Taken branch: one flush cycle
      ex_branch_taken = 1'b1;
      #1 chk_out("br", 5'b11111, 2'b11, 1'b0, 2'd0);
      tick(); ex_branch_taken = 1'b0;
      #1 chk_out("br_after", 5'b11111, 2'b00, 1'b0, 2'd0);

      // Branch during LOAD_STALL ends the stall
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      tick(); clr_in(); ex_branch_taken = 1'b1;
      #1 chk_out("ls_br", 5'b11111, 2'b11, 1'b0, 2'd1);
      tick(); ex_branch_taken = 1'b0;
      #1 chk_out("ls_br_done", 5'b11111, 2'b00, 1'b0, 2'd0);
      chk_perf("perf_br", 5, 2, 0);

      // Memory freeze suspends LOAD_STALL; the stall resumes afterwards
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      tick(); clr_in(); mem_access = 1'b1;
      #1 chk_out("ls_frz", 5'b00000, 2'b00, 1'b0, 2'd1);
      tick();
      #1 chk_out("ls_mw", 5'b00000, 2'b00, 1'b0, 2'd2);
      tick(); mem_ready = 1'b1;
      #1 chk_out("ls_resume", 5'b00111, 2'b01, 1'b0, 2'd2);
      tick(); clr_in();
      #1 chk_out("ls_res_done", 5'b11111, 2'b00, 1'b0, 2'd0);

      // Freeze beats branch for 4 cycles; timeout after 3rd MEM_WAIT cycle
      mem_access = 1'b1; ex_branch_taken = 1'b1;
      #1 chk_out("frz0", 5'b00000, 2'b00, 1'b0, 2'd0);
      tick(); #1 chk_out("frz1", 5'b00000, 2'b00, 1'b0, 2'd2);
      tick(); #1 chk_out("frz2", 5'b00000, 2'b00, 1'b0, 2'd2);
      tick(); #1 chk_out("frz3", 5'b00000, 2'b00, 1'b0, 2'd2);
      tick(); #1 chk_out("frz_to", 5'b00000, 2'b00, 1'b1, 2'd2);
      tick(); mem_ready = 1'b1;
      #1 chk_out("frz_exit", 5'b11111, 2'b11, 1'b1, 2'd2);
      chk_d1("d1_frz_exit", 5'b11111, 2'd2);
      chk("d1_no_err", 32'(d1_mem_err), 32'd0);
      tick(); clr_in();
      #1 chk_out("err_sticky", 5'b11111, 2'b00, 1'b1, 2'd0);
      chk_perf("perf_frz", 8, 3, 7);

      // Only reset clears mem_err, and the flag is masked while rst is high
      rst = 1'b1;
      #1 chk_out("rst_err", 5'b00000, 2'b11, 1'b0, 2'd0);
      tick(); rst = 1'b0;
      #1 chk_out("rst_err_clr", 5'b11111, 2'b00, 1'b0, 2'd0);
      chk_perf("perf_clr", 0, 0, 0);

      // Reset in the middle of LOAD_STALL aborts it
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      tick(); clr_in(); rst = 1'b1;
      #1 chk_out("rst_ls", 5'b00000, 2'b11, 1'b0, 2'd1);
      tick(); rst = 1'b0;
      #1 chk_out("rst_ls_done", 5'b11111, 2'b00, 1'b0, 2'd0);
      chk_perf("perf_rst_ls", 0, 0, 0);

      // A fresh hazard after the abort still costs exactly two cycles
      ex_memread = 1'b1; ex_rt = 5'd8; id_rt = 5'd8;
      #1 chk_out("lu2_c0", 5'b00111, 2'b01, 1'b0, 2'd0);
      tick(); clr_in();
      #1 chk_out("lu2_c1", 5'b00111, 2'b01, 1'b0, 2'd1);
      tick();
      #1 chk_out("lu2_done", 5'b11111, 2'b00, 1'b0, 2'd0);
      chk_perf("perf_lu2", 2, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
